bcd_to_bin_seq: RTL

Sequential BCD-to-binary converter: the inverse of the team's binary-to-BCD digit splitter. It takes a packed 4-digit BCD value, for example from a digit-entry UI built on the button counters, and produces the equivalent unsigned binary number. It uses reverse double-dabble, with one shift/correct step per clock, behind a start/busy/done handshake. It sits between BCD user-entry logic and any arithmetic block that needs a plain binary count.

---
 rtl/bcd_to_bin_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// One shift/correct step per clock behind a start/busy/done handshake.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t             state, state_nxt;
  logic [SR_W-1:0]    sr, sr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               inv, inv_nxt;
  logic [BIN_W-1:0]   bin_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               err_nxt;

  function automatic logic digits_ok(
    input logic [BCD_W-1:0] v
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Shift right, then pull every digit >= 8 back down by 3.
  function automatic logic [SR_W-1:0] step(
    input logic [SR_W-1:0] s
  );
    logic [SR_W-1:0] t;
    logic [3:0]      d;
    t = s >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = t[BIN_W + 4*i +: 4];
      if (d >= 4'd8) t[BIN_W + 4*i +: 4] = d - 4'd3;
    end
    return t;
  endfunction

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      inv     <= 1'b0;
      bin_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      cnt     <= cnt_nxt;
      inv     <= inv_nxt;
      bin_out <= bin_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    inv_nxt   = inv;
    bin_nxt   = bin_out;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = err;
    unique case (state)
      IDLE: begin
        if (start) begin
          busy_nxt = 1'b1;
          if (digits_ok(bcd_in)) begin
            sr_nxt    = {bcd_in, {BIN_W{1'b0}}};
            cnt_nxt   = '0;
            inv_nxt   = 1'b0;
            state_nxt = SHIFT;
          end else begin
            inv_nxt   = 1'b1;
            state_nxt = FINISH;
          end
        end
      end
      SHIFT: begin
        sr_nxt  = step(sr);
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(BIN_W - 1)) state_nxt = FINISH;
      end
      FINISH: begin
        bin_nxt   = inv ? '0 : sr[BIN_W-1:0];
        err_nxt   = inv;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
